ts_sync_aligner: RTL and testbench
==================================

Name: ts_sync_aligner

Overview:
- Input-side stage between the reclock FIFO output and t2mi_packer TS input, in the BOARD_CLK domain.
- Hunts for MPEG-TS sync bytes (0x47) in a byte stream with a valid strobe, and verifies packet periodicity.
- Once locked, forwards only whole packets that start with a correct sync byte, and marks each packet's first byte with a PSYNC flag.
- Reports lock state and counts dropped or missed-sync packets for status readback.

Parameters:
- PKT_LEN, 188, packet length in bytes (range 2..255).
- SYNC_BYTE, 8'h47, expected sync byte value.
- LOCK_CNT, 3, consecutive correct sync bytes needed to enter LOCK (range 2..7).
- UNLOCK_CNT, 3, consecutive missed sync bytes in LOCK that force a return to HUNT (range 1..7).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous active-high reset.
- DATA_IN  in  8  TS byte.
- DVALID_IN  in  1  DATA_IN qualifier; one byte per cycle when high; gaps allowed.
- DATA_OUT  out  8  forwarded TS byte.
- DVALID_OUT  out  1  DATA_OUT qualifier.
- PSYNC_OUT  out  1  high with the first byte (the sync byte) of each forwarded packet.
- LOCKED  out  1  high while in LOCK.
- DROP_CNT  out  16  saturating count of packets not forwarded while in LOCK.

Behaviour:
- Everything is evaluated only on cycles with DVALID_IN=1; on idle cycles all counters and state hold.
- byte_cnt, 8 bit: position within the current packet, 0..PKT_LEN-1. Wraps PKT_LEN-1 -> 0. "Boundary" means a valid byte arriving with byte_cnt==0.
- Latency: fixed 1 cycle. DATA_OUT, DVALID_OUT and PSYNC_OUT are registered copies of the accepted byte.
- Reset values:
  - DATA_OUT=0, DVALID_OUT=0, PSYNC_OUT=0, LOCKED=0, DROP_CNT=0.
  - State=HUNT, byte_cnt=0, hit=0, miss=0, fwd=0.
- HUNT:
  - Valid byte == SYNC_BYTE: hit=1, byte_cnt=1, go to VERIFY.
  - Otherwise stay in HUNT.
  - Nothing is forwarded.
- VERIFY:
  - byte_cnt advances on each valid byte.
  - At a boundary with a correct sync byte: hit++. If hit reaches LOCK_CNT, go to LOCK and forward this packet starting with this byte.
  - At a boundary with a wrong byte: hit=0, go to HUNT. The offending byte is not re-examined as a sync candidate.
  - Nothing is forwarded while in VERIFY.
- LOCK:
  - LOCKED=1 starting the cycle after entry.
  - Boundary byte correct: miss=0, fwd=1. The byte is output with PSYNC_OUT=1, and the following PKT_LEN-1 valid bytes are output with PSYNC_OUT=0.
  - Boundary byte wrong: miss++, fwd=0. The whole packet (PKT_LEN bytes) is suppressed and DROP_CNT increments, saturating at 16'hFFFF.
  - Alignment is flywheeled: byte_cnt keeps counting through the suppressed packet.
  - If miss reaches UNLOCK_CNT: go to HUNT, LOCKED=0 the next cycle, hit=0, miss=0.
- Packet integrity: once the first byte of a packet is forwarded, exactly PKT_LEN bytes are forwarded for it. A lock loss can only occur at a boundary, so no partial packet ever reaches the output.
- Bytes inside a packet are never checked for SYNC_BYTE. A 0x47 in the payload has no effect.
- RST mid-packet: state returns to reset values on the next edge. Outputs drop in the same cycle RST is sampled. Any partially output packet is abandoned.
- DVALID_OUT=0 implies PSYNC_OUT=0 and DATA_OUT holds its last value.

Test Plan:
- Reset, then a clean 188-byte packet stream starting with 0x47, DVALID_IN always high -> packets 1 and 2 are not forwarded. The first DVALID_OUT/PSYNC_OUT occurs 1 cycle after the 3rd 0x47 (input byte index 376). LOCKED rises on the same edge. Exactly 188 DVALID_OUT cycles are produced per packet.
- 37 junk bytes (no 0x47) before a clean stream -> HUNT skips them; the first output packet starts with the input byte at index 37+376; DROP_CNT=0.
- While locked, packet N has its first byte corrupted to 0x00 -> packet N is fully suppressed (188 bytes), DROP_CNT=1, LOCKED stays 1, and packet N+1 is forwarded normally.
- While locked, 3 consecutive packets have bad sync -> DROP_CNT=3. LOCKED falls 1 cycle after the 3rd bad boundary byte. After that, lock is reacquired on the 3rd good sync.
- Random DVALID_IN gaps (about 50% duty) with a clean stream -> the output byte sequence is identical to the gap-free case, PSYNC_OUT appears only on 0x47 bytes, and every packet has 188 valid bytes.
- RST pulsed for 1 cycle at byte 100 of a forwarded packet -> all outputs 0 the next cycle, LOCKED=0, DROP_CNT=0, and the block re-enters HUNT.

Source files
------------

// File: rtl/ts_sync_aligner.sv
// ts_sync_aligner: MPEG-TS sync hunter / packet aligner.
// Hunts for the sync byte in a gapped byte stream, confirms packet periodicity,
// then forwards only whole packets that start with a correct sync byte.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   DATA_IN         input TS byte, qualified by DVALID_IN
//   DATA_OUT        forwarded byte (1-cycle latency), qualified by DVALID_OUT
//   PSYNC_OUT       marks the first (sync) byte of each forwarded packet
//   LOCKED          high while in the locked state
//   DROP_CNT        saturating count of packets suppressed while locked
module ts_sync_aligner #(
  parameter int unsigned PKT_LEN    = 188,
  parameter logic [7:0]  SYNC_BYTE  = 8'h47,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        DVALID_IN,
  output logic [7:0]  DATA_OUT,
  output logic        DVALID_OUT,
  output logic        PSYNC_OUT,
  output logic        LOCKED,
  output logic [15:0] DROP_CNT
);

  localparam logic [7:0] LastIdx    = 8'(PKT_LEN - 1);
  localparam logic [2:0] LockHits   = 3'(LOCK_CNT);
  localparam logic [2:0] UnlockMiss = 3'(UNLOCK_CNT);

  typedef enum logic [1:0] {StHunt, StVerify, StLock} state_e;

  state_e      state_q, state_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  hit_q, hit_d;
  logic [2:0]  miss_q, miss_d;
  logic        fwd_q, fwd_d;
  logic [7:0]  data_q, data_d;
  logic        dvalid_q, dvalid_d;
  logic        psync_q, psync_d;
  logic [15:0] drop_q, drop_d;

  logic       boundary;
  logic       is_sync;
  logic [7:0] cnt_inc;

  assign boundary = (byte_cnt_q == 8'd0);
  assign is_sync  = (DATA_IN == SYNC_BYTE);
  assign cnt_inc  = (byte_cnt_q == LastIdx) ? 8'd0 : byte_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    fwd_d      = fwd_q;
    data_d     = data_q;
    drop_d     = drop_q;
    dvalid_d   = 1'b0;
    psync_d    = 1'b0;

    if (DVALID_IN) begin
      unique case (state_q)
        StHunt: begin
          if (is_sync) begin
            hit_d      = 3'd1;
            byte_cnt_d = 8'd1;
            state_d    = StVerify;
          end
        end

        StVerify: begin
          if (boundary && !is_sync) begin
            // The failing byte is consumed here, not retried as a new candidate.
            hit_d      = 3'd0;
            byte_cnt_d = 8'd0;
            state_d    = StHunt;
          end else begin
            byte_cnt_d = cnt_inc;
            if (boundary) begin
              hit_d = hit_q + 3'd1;
              if (hit_q + 3'd1 == LockHits) begin
                // The packet that completes the lock is forwarded in full.
                state_d  = StLock;
                miss_d   = 3'd0;
                fwd_d    = 1'b1;
                dvalid_d = 1'b1;
                psync_d  = 1'b1;
                data_d   = DATA_IN;
              end
            end
          end
        end

        StLock: begin
          byte_cnt_d = cnt_inc;
          if (boundary) begin
            if (is_sync) begin
              miss_d   = 3'd0;
              fwd_d    = 1'b1;
              dvalid_d = 1'b1;
              psync_d  = 1'b1;
              data_d   = DATA_IN;
            end else begin
              fwd_d  = 1'b0;
              drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
              miss_d = miss_q + 3'd1;
              if (miss_q + 3'd1 == UnlockMiss) begin
                state_d    = StHunt;
                hit_d      = 3'd0;
                miss_d     = 3'd0;
                byte_cnt_d = 8'd0;
              end
            end
          end else if (fwd_q) begin
            dvalid_d = 1'b1;
            data_d   = DATA_IN;
          end
        end

        default: begin
          state_d    = StHunt;
          byte_cnt_d = 8'd0;
          hit_d      = 3'd0;
          miss_d     = 3'd0;
          fwd_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StHunt;
      byte_cnt_q <= 8'd0;
      hit_q      <= 3'd0;
      miss_q     <= 3'd0;
      fwd_q      <= 1'b0;
      data_q     <= 8'd0;
      dvalid_q   <= 1'b0;
      psync_q    <= 1'b0;
      drop_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      fwd_q      <= fwd_d;
      data_q     <= data_d;
      dvalid_q   <= dvalid_d;
      psync_q    <= psync_d;
      drop_q     <= drop_d;
    end
  end

  assign DATA_OUT   = data_q;
  assign DVALID_OUT = dvalid_q;
  assign PSYNC_OUT  = psync_q;
  assign LOCKED     = (state_q == StLock);
  assign DROP_CNT   = drop_q;

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Testbench for ts_sync_aligner: random-payload TS streams with optional input gaps,
// checked cycle by cycle against a stream-scanning reference model.
module tb_ts_sync_aligner;

  localparam int         PktLen    = 188;
  localparam int         LockCnt   = 3;
  localparam int         UnlockCnt = 3;
  localparam logic [7:0] Sync      = 8'h47;
  localparam int         MaxN      = 4096;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  DATA_IN;
  logic        DVALID_IN;
  logic [7:0]  DATA_OUT;
  logic        DVALID_OUT;
  logic        PSYNC_OUT;
  logic        LOCKED;
  logic [15:0] DROP_CNT;

  ts_sync_aligner #(
    .PKT_LEN   (PktLen),
    .SYNC_BYTE (Sync),
    .LOCK_CNT  (LockCnt),
    .UNLOCK_CNT(UnlockCnt)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DATA_IN   (DATA_IN),
    .DVALID_IN (DVALID_IN),
    .DATA_OUT  (DATA_OUT),
    .DVALID_OUT(DVALID_OUT),
    .PSYNC_OUT (PSYNC_OUT),
    .LOCKED    (LOCKED),
    .DROP_CNT  (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int    checks = 0;
  int    failures = 0;
  string cur_tag = "init";

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL [%s] %s obs=0x%0h exp=0x%0h", cur_tag, tag, obs, exp);
    end
  endtask

  // Stimulus and model results, indexed by valid-byte number.
  logic [7:0] stim[$];
  bit         m_fwd[MaxN];
  bit         m_ps[MaxN];
  bit         m_lk[MaxN];
  int         m_dr[MaxN];
  bit         lk_set[MaxN];
  bit         lk_clr[MaxN];
  bit         dinc[MaxN];

  // Observation bookkeeping.
  logic [7:0] exp_data;
  bit         cur_lk;
  int         cur_dr;
  int         first_idx;
  int         fwd_seen;
  int         psq[$];
  logic [7:0] outq[$];
  logic [7:0] clean_out[$];
  logic [7:0] clean_stim[$];

  task automatic build_stream(input int npk, input int junk, input int bad_lo, input int bad_hi,
                              input bit no47);
    logic [7:0] b;
    stim.delete();
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom);
      if (b == Sync) b = 8'h00;
      stim.push_back(b);
    end
    for (int p = 0; p < npk; p++) begin
      stim.push_back((p >= bad_lo && p <= bad_hi) ? 8'h00 : Sync);
      for (int k = 1; k < PktLen; k++) begin
        b = 8'($urandom);
        if (no47 && b == Sync) b = 8'h48;
        stim.push_back(b);
      end
    end
  endtask

  // Scans the stream as whole packets: find a sync, confirm LockCnt syncs at PktLen
  // spacing, then walk packet starts until UnlockCnt consecutive bad ones.
  function automatic void run_model();
    int n;
    int i;
    int p;
    int q;
    int hits;
    int misses;
    int dr;
    bit lk;
    bit back_to_hunt;
    n = stim.size();
    for (int k = 0; k < MaxN; k++) begin
      m_fwd[k] = 0; m_ps[k] = 0; m_lk[k] = 0; m_dr[k] = 0;
      lk_set[k] = 0; lk_clr[k] = 0; dinc[k] = 0;
    end
    i = 0;
    while (i < n) begin
      if (stim[i] != Sync) begin
        i++;
      end else begin
        hits = 1;
        p = i + PktLen;
        back_to_hunt = 0;
        while (hits < LockCnt && !back_to_hunt) begin
          if (p >= n) begin
            back_to_hunt = 1;
            i = n;
          end else if (stim[p] == Sync) begin
            hits++;
            if (hits < LockCnt) p += PktLen;
          end else begin
            back_to_hunt = 1;
            i = p + 1;
          end
        end
        if (!back_to_hunt) begin
          lk_set[p] = 1;
          misses = 0;
          q = p;
          while (q < n && misses < UnlockCnt) begin
            if (stim[q] == Sync) begin
              misses = 0;
              m_ps[q] = 1;
              for (int k = q; k < q + PktLen && k < n; k++) m_fwd[k] = 1;
            end else begin
              misses++;
              dinc[q] = 1;
              if (misses == UnlockCnt) lk_clr[q] = 1;
            end
            q += PktLen;
          end
          i = (misses == UnlockCnt) ? q - PktLen + 1 : n;
        end
      end
    end
    lk = 0;
    dr = 0;
    for (int k = 0; k < n; k++) begin
      if (lk_set[k]) lk = 1;
      if (lk_clr[k]) lk = 0;
      if (dinc[k] && dr < 65535) dr++;
      m_lk[k] = lk;
      m_dr[k] = dr;
    end
  endfunction

  task automatic check_idle();
    check_eq("idle_dvalid", 32'(DVALID_OUT), 32'd0);
    check_eq("idle_psync", 32'(PSYNC_OUT), 32'd0);
    check_eq("idle_data", 32'(DATA_OUT), 32'(exp_data));
    check_eq("idle_locked", 32'(LOCKED), 32'(cur_lk));
    check_eq("idle_drop", 32'(DROP_CNT), 32'(cur_dr));
  endtask

  task automatic check_byte(input int j);
    if (m_fwd[j]) exp_data = stim[j];
    cur_lk = m_lk[j];
    cur_dr = m_dr[j];
    check_eq("dvalid", 32'(DVALID_OUT), 32'(m_fwd[j]));
    check_eq("psync", 32'(PSYNC_OUT), 32'(m_ps[j]));
    check_eq("data", 32'(DATA_OUT), 32'(exp_data));
    check_eq("locked", 32'(LOCKED), 32'(cur_lk));
    check_eq("drop", 32'(DROP_CNT), 32'(cur_dr));
    if (PSYNC_OUT) begin
      check_eq("psync_on_sync", 32'(DATA_OUT), 32'(Sync));
      psq.push_back(j);
    end
    if (DVALID_OUT) begin
      outq.push_back(DATA_OUT);
      fwd_seen++;
      if (first_idx < 0) first_idx = j;
    end
  endtask

  task automatic check_zero(input string what);
    check_eq({what, "_dvalid"}, 32'(DVALID_OUT), 32'd0);
    check_eq({what, "_psync"}, 32'(PSYNC_OUT), 32'd0);
    check_eq({what, "_data"}, 32'(DATA_OUT), 32'd0);
    check_eq({what, "_locked"}, 32'(LOCKED), 32'd0);
    check_eq({what, "_drop"}, 32'(DROP_CNT), 32'd0);
    exp_data = 8'd0;
    cur_lk = 0;
    cur_dr = 0;
  endtask

  task automatic run_stream(input string tag, input int gap_pct, input int stop_at,
                            input bit do_reset);
    int g;
    cur_tag = tag;
    run_model();
    if (do_reset) begin
      RST = 1'b1;
      DVALID_IN = 1'b0;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      check_zero("reset");
    end
    first_idx = -1;
    fwd_seen = 0;
    psq.delete();
    outq.delete();
    for (int j = 0; j < stim.size(); j++) begin
      g = 0;
      while (gap_pct > 0 && g < 8 && $urandom_range(99) < gap_pct) begin
        DVALID_IN = 1'b0;
        DATA_IN = 8'($urandom);
        @(posedge CLK);
        #1;
        check_idle();
        g++;
      end
      DVALID_IN = 1'b1;
      DATA_IN = stim[j];
      @(posedge CLK);
      #1;
      check_byte(j);
      if (stop_at >= 0 && j == stop_at) break;
    end
    DVALID_IN = 1'b0;
    DATA_IN = 8'h00;
    if (stop_at >= 0) begin
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      check_zero("midreset");
    end else begin
      @(posedge CLK);
      #1;
      check_idle();
    end
  endtask

  initial begin : main
    int relock;
    int diffs;
    RST = 1'b1;
    DVALID_IN = 1'b0;
    DATA_IN = 8'h00;
    exp_data = 8'h00;
    cur_lk = 0;
    cur_dr = 0;
    repeat (2) @(posedge CLK);
    #1;

    // Clean gap-free stream: lock on the third sync, first output at byte 376.
    build_stream(10, 0, -1, -1, 1'b0);
    run_stream("clean", 0, -1, 1'b1);
    check_eq("first_out_idx", 32'(first_idx), 32'd376);
    check_eq("fwd_bytes", 32'(fwd_seen), 32'(8 * PktLen));
    clean_out = outq;
    clean_stim = stim;

    // Junk prefix without sync bytes.
    build_stream(8, 37, -1, -1, 1'b0);
    run_stream("junk37", 0, -1, 1'b1);
    check_eq("first_out_idx", 32'(first_idx), 32'd413);
    check_eq("drop_end", 32'(DROP_CNT), 32'd0);

    // Single corrupted sync while locked.
    build_stream(8, 0, 5, 5, 1'b0);
    run_stream("onebad", 0, -1, 1'b1);
    check_eq("drop_end", 32'(DROP_CNT), 32'd1);
    check_eq("locked_end", 32'(LOCKED), 32'd1);
    check_eq("fwd_bytes", 32'(fwd_seen), 32'(5 * PktLen));

    // Three consecutive bad syncs force unlock, then relock on the third good sync.
    build_stream(12, 0, 4, 6, 1'b1);
    run_stream("threebad", 0, -1, 1'b1);
    check_eq("drop_end", 32'(DROP_CNT), 32'd3);
    check_eq("locked_end", 32'(LOCKED), 32'd1);
    relock = -1;
    foreach (psq[k]) if (relock < 0 && psq[k] > 6 * PktLen) relock = psq[k];
    check_eq("relock_idx", 32'(relock), 32'(9 * PktLen));

    // Same clean stream with ~50% input gaps: output byte sequence must be identical.
    stim = clean_stim;
    run_stream("gaps", 50, -1, 1'b1);
    check_eq("gap_out_len", 32'(outq.size()), 32'(clean_out.size()));
    diffs = 0;
    foreach (outq[k]) if (k < clean_out.size() && outq[k] != clean_out[k]) diffs++;
    check_eq("gap_out_diffs", 32'(diffs), 32'd0);

    // Reset pulse at byte 100 of a forwarded packet (after one drop).
    build_stream(8, 0, 3, 3, 1'b0);
    run_stream("midrst", 0, 4 * PktLen + 100, 1'b1);

    // Continue straight from the mid-packet reset: block must hunt and relock afresh.
    build_stream(6, 0, -1, -1, 1'b0);
    run_stream("after_rst", 30, -1, 1'b0);
    check_eq("first_out_idx", 32'(first_idx), 32'd376);
    check_eq("fwd_bytes", 32'(fwd_seen), 32'(4 * PktLen));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
